// File: rtl/factorial_pkg.sv
// Shared definitions for the factorial engine controller.
//   - register select codes (s_addr[5:3]) for the bus-mapped CSRs
//   - sequencing FSM state encoding
//   - bit positions inside OPDONE and MODE/STATUS
package factorial_pkg;

  localparam logic [2:0] OFS_OPSTART  = 3'd0;  // 0x00
  localparam logic [2:0] OFS_OPCLEAR  = 3'd1;  // 0x08
  localparam logic [2:0] OFS_OPDONE   = 3'd2;  // 0x10
  localparam logic [2:0] OFS_INTREN   = 3'd3;  // 0x18
  localparam logic [2:0] OFS_OPERAND  = 3'd4;  // 0x20
  localparam logic [2:0] OFS_RESULT_H = 3'd5;  // 0x28
  localparam logic [2:0] OFS_RESULT_L = 3'd6;  // 0x30
  localparam logic [2:0] OFS_STATUS   = 3'd7;  // 0x38

  localparam int OPDONE_DONE_BIT = 0;
  localparam int OPDONE_BUSY_BIT = 1;
  localparam int STATUS_MODE_BIT = 0;
  localparam int STATUS_OVF_BIT  = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4,
    ST_ABORT = 3'd5
  } state_t;

endpackage

// File: rtl/factorial_regfile.sv
// Control/status register file for the factorial engine.
// Decodes bus writes into OPSTART (one-cycle pulse), OPCLEAR (level), INTREN,
// OPERAND and MODE; OPSTART/OPERAND/MODE writes are dropped while the engine
// is busy. Reads are a combinational mux, zero when not selected or unmapped.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   s_sel/s_wr/s_addr/s_din/s_dout   register bus
//   busy, done, ovf, acc  live engine status shown on reads
//   opstart, opclear, intren, operand, mode   register outputs to the FSM
module factorial_regfile
  import factorial_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int RESULT_W = 128
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                s_sel,
  input  logic                s_wr,
  input  logic [15:0]         s_addr,
  input  logic [63:0]         s_din,
  output logic [63:0]         s_dout,
  input  logic                busy,
  input  logic                done,
  input  logic                ovf,
  input  logic [RESULT_W-1:0] acc,
  output logic                opstart,
  output logic                opclear,
  output logic                intren,
  output logic [DATA_W-1:0]   operand,
  output logic                mode
);

  logic [2:0]   sel;
  logic         hit;
  logic         wr;
  logic         rd;
  logic [127:0] acc_ext;
  logic         unused_bits;

  // Only the first 64 bytes are mapped; byte lanes within a register are ignored.
  assign sel         = s_addr[5:3];
  assign hit         = (s_addr[15:6] == '0);
  assign wr          = s_sel & s_wr & hit;
  assign rd          = s_sel & ~s_wr & hit;
  // Zero-extension makes RESULT_H read 0 for a 64-bit accumulator.
  assign acc_ext     = 128'(acc);
  assign unused_bits = ^{s_addr[2:0], s_din};

  always_ff @(posedge clk) begin
    if (reset) begin
      opstart <= 1'b0;
      opclear <= 1'b0;
      intren  <= 1'b0;
      operand <= '0;
      mode    <= 1'b0;
    end else begin
      opstart <= wr && (sel == OFS_OPSTART) && s_din[0] && !busy;
      if (wr) begin
        case (sel)
          OFS_OPCLEAR: opclear <= s_din[0];
          OFS_INTREN:  intren  <= s_din[0];
          OFS_OPERAND: if (!busy) operand <= s_din[DATA_W-1:0];
          OFS_STATUS:  if (!busy) mode <= s_din[STATUS_MODE_BIT];
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    s_dout = '0;
    if (rd) begin
      case (sel)
        OFS_OPDONE: begin
          s_dout[OPDONE_DONE_BIT] = done;
          s_dout[OPDONE_BUSY_BIT] = busy;
        end
        OFS_INTREN:   s_dout[0] = intren;
        OFS_OPERAND:  s_dout = 64'(operand);
        OFS_RESULT_H: s_dout = acc_ext[127:64];
        OFS_RESULT_L: s_dout = acc_ext[63:0];
        OFS_STATUS: begin
          s_dout[STATUS_MODE_BIT] = mode;
          s_dout[STATUS_OVF_BIT]  = ovf;
        end
        default: s_dout = '0;
      endcase
    end
  end

endmodule

// File: rtl/factorial_engine_ctrl.sv
// Factorial engine controller: CSRs plus the sequencing FSM that computes
// n! (MODE=0) or n!! (MODE=1) by driving an external iterative multiplier.
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   s_sel/s_wr/s_addr/s_din/s_dout register bus
//   mul_start, mul_clear, mul_a, mul_b    multiplier request side
//   mul_done, mul_result          multiplier completion (result valid with done)
//   intr                          level interrupt, INTREN & done
module factorial_engine_ctrl
  import factorial_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int RESULT_W = 128
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       s_sel,
  input  logic                       s_wr,
  input  logic [15:0]                s_addr,
  input  logic [63:0]                s_din,
  output logic [63:0]                s_dout,
  output logic                       mul_start,
  output logic                       mul_clear,
  output logic [RESULT_W-1:0]        mul_a,
  output logic [DATA_W-1:0]          mul_b,
  input  logic                       mul_done,
  input  logic [RESULT_W+DATA_W-1:0] mul_result,
  output logic                       intr
);

  state_t              state;
  logic [RESULT_W-1:0] acc;
  logic [DATA_W-1:0]   factor;
  logic [DATA_W-1:0]   factor_dec;
  logic [1:0]          step;
  logic                ovf;
  logic                done;
  logic                busy;
  logic                opstart;
  logic                opclear;
  logic                intren;
  logic                mode;
  logic [DATA_W-1:0]   operand;

  factorial_regfile #(
    .DATA_W   (DATA_W),
    .RESULT_W (RESULT_W)
  ) u_regfile (
    .clk     (clk),
    .reset   (reset),
    .s_sel   (s_sel),
    .s_wr    (s_wr),
    .s_addr  (s_addr),
    .s_din   (s_din),
    .s_dout  (s_dout),
    .busy    (busy),
    .done    (done),
    .ovf     (ovf),
    .acc     (acc),
    .opstart (opstart),
    .opclear (opclear),
    .intren  (intren),
    .operand (operand),
    .mode    (mode)
  );

  // acc and factor only move on mul_done or abort, so the multiplier operands
  // stay stable for the whole request.
  assign mul_a = acc;
  assign mul_b = factor;
  assign intr  = intren & done;

  assign factor_dec = (factor >= DATA_W'(step)) ? factor - DATA_W'(step) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      acc       <= RESULT_W'(1);
      factor    <= '0;
      step      <= 2'd1;
      ovf       <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      mul_start <= 1'b0;
      mul_clear <= 1'b1;
    end else begin
      mul_start <= 1'b0;
      // OPCLEAR overrides everything, including a coincident mul_done.
      if (opclear) begin
        state     <= ST_ABORT;
        acc       <= RESULT_W'(1);
        ovf       <= 1'b0;
        done      <= 1'b0;
        busy      <= 1'b0;
        mul_clear <= 1'b1;
      end else begin
        case (state)
          ST_IDLE, ST_DONE: begin
            if (opstart) begin
              state     <= ST_CHECK;
              factor    <= operand;
              step      <= mode ? 2'd2 : 2'd1;
              acc       <= RESULT_W'(1);
              ovf       <= 1'b0;
              done      <= 1'b0;
              busy      <= 1'b1;
              mul_clear <= 1'b0;
            end
          end
          ST_CHECK: begin
            if (factor <= DATA_W'(1)) begin
              state <= ST_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              // Registered so the pulse coincides with the ISSUE cycle.
              state     <= ST_ISSUE;
              mul_start <= 1'b1;
            end
          end
          ST_ISSUE: state <= ST_WAIT;
          ST_WAIT: begin
            if (mul_done) begin
              acc    <= mul_result[RESULT_W-1:0];
              ovf    <= ovf | (|mul_result[RESULT_W+DATA_W-1:RESULT_W]);
              factor <= factor_dec;
              state  <= ST_CHECK;
            end
          end
          ST_ABORT: state <= ST_IDLE;
          default:  state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_factorial_engine_ctrl.sv
// Bench for factorial_engine_ctrl: two instances (RESULT_W=128 and 64) share
// one register bus; each has its own latency-L multiplier model. Results are
// compared with a plain big-integer factorial model.
module tb_factorial_engine_ctrl;

  localparam logic [15:0] A_OPSTART  = 16'h00;
  localparam logic [15:0] A_OPCLEAR  = 16'h08;
  localparam logic [15:0] A_OPDONE   = 16'h10;
  localparam logic [15:0] A_INTREN   = 16'h18;
  localparam logic [15:0] A_OPERAND  = 16'h20;
  localparam logic [15:0] A_RESULT_H = 16'h28;
  localparam logic [15:0] A_RESULT_L = 16'h30;
  localparam logic [15:0] A_STATUS   = 16'h38;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic s_sel = 1'b0, s_wr = 1'b0;
  logic [15:0] s_addr = '0;
  logic [63:0] s_din = '0;

  logic [63:0]  d128_s_dout, d64_s_dout;
  logic         d128_mul_start, d128_mul_clear, d128_intr;
  logic         d64_mul_start, d64_mul_clear, d64_intr;
  logic [127:0] d128_mul_a;
  logic [63:0]  d64_mul_a, d128_mul_b, d64_mul_b;
  logic         d128_mul_done = 1'b0, d64_mul_done = 1'b0;
  logic [191:0] d128_mul_result = '0, p128 = '0;
  logic [127:0] d64_mul_result = '0, p64 = '0;

  int mul_lat = 3;
  int c128 = 0, c64 = 0, d128_starts = 0, d64_starts = 0;
  int checks = 0, fails = 0;
  int last_cyc;
  logic [63:0] last_h128, last_l128, last_h64, last_l64;
  bit last_ovf128, last_ovf64;

  always #5 clk = ~clk;

  factorial_engine_ctrl #(.DATA_W(64), .RESULT_W(128)) dut128 (
    .clk(clk), .reset(reset), .s_sel(s_sel), .s_wr(s_wr), .s_addr(s_addr), .s_din(s_din),
    .s_dout(d128_s_dout), .mul_start(d128_mul_start), .mul_clear(d128_mul_clear),
    .mul_a(d128_mul_a), .mul_b(d128_mul_b), .mul_done(d128_mul_done),
    .mul_result(d128_mul_result), .intr(d128_intr));

  factorial_engine_ctrl #(.DATA_W(64), .RESULT_W(64)) dut64 (
    .clk(clk), .reset(reset), .s_sel(s_sel), .s_wr(s_wr), .s_addr(s_addr), .s_din(s_din),
    .s_dout(d64_s_dout), .mul_start(d64_mul_start), .mul_clear(d64_mul_clear),
    .mul_a(d64_mul_a), .mul_b(d64_mul_b), .mul_done(d64_mul_done),
    .mul_result(d64_mul_result), .intr(d64_intr));

  // Multiplier models: done is high across the edge mul_lat cycles after the
  // edge that samples mul_start.
  always @(negedge clk) begin
    if (reset) begin
      c128 = 0; d128_mul_done = 1'b0;
    end else begin
      d128_mul_done = 1'b0;
      if (c128 > 0) begin
        c128--;
        if (c128 == 0) begin d128_mul_done = 1'b1; d128_mul_result = p128; end
      end
      if (d128_mul_start) begin
        c128 = mul_lat; p128 = 192'(d128_mul_a) * 192'(d128_mul_b); d128_starts++;
      end
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      c64 = 0; d64_mul_done = 1'b0;
    end else begin
      d64_mul_done = 1'b0;
      if (c64 > 0) begin
        c64--;
        if (c64 == 0) begin d64_mul_done = 1'b1; d64_mul_result = p64; end
      end
      if (d64_mul_start) begin
        c64 = mul_lat; p64 = 128'(d64_mul_a) * 128'(d64_mul_b); d64_starts++;
      end
    end
  end

  // n! or n!! truncated to rw bits, sticky overflow, number of multiplies.
  function automatic void model(input longint unsigned n, input bit dbl, input int rw,
                                output logic [127:0] res, output bit ovf, output int muls);
    logic [255:0] acc, p, mask;
    mask = (256'd1 << rw) - 256'd1;
    acc = 256'd1; ovf = 1'b0; muls = 0;
    for (longint unsigned f = n; f > 1; f -= (dbl ? 2 : 1)) begin
      p = acc * 256'(f);
      if ((p & ~mask) != 0) ovf = 1'b1;
      acc = p & mask;
      muls++;
    end
    res = acc[127:0];
  endfunction

  task automatic bus_write(input logic [15:0] a, input logic [63:0] d);
    @(negedge clk);
    s_sel = 1'b1; s_wr = 1'b1; s_addr = a; s_din = d;
    @(negedge clk);
    s_sel = 1'b0; s_wr = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [63:0] r128, output logic [63:0] r64);
    s_sel = 1'b1; s_wr = 1'b0; s_addr = a;
    #1;
    r128 = d128_s_dout; r64 = d64_s_dout;
    s_sel = 1'b0;
  endtask

  // Writes OPSTART; cyc = k where OPDONE[0] is first seen after edge t+k.
  task automatic start_and_wait(output int cyc, output bit to);
    logic [63:0] r1, r2;
    bus_write(A_OPSTART, 64'd1);
    cyc = 0; to = 1'b1;
    while (cyc < 3000) begin
      @(negedge clk); cyc++;
      bus_read(A_OPDONE, r1, r2);
      if (r1[0] && r2[0]) begin to = 1'b0; break; end
    end
  endtask

  task automatic run_op(input int unsigned n, input bit dbl);
    logic [127:0] e128, e64;
    bit eo128, eo64, to;
    int m128, m64, s128, s64, cyc;
    logic [63:0] r1, r2;
    model(64'(n), dbl, 128, e128, eo128, m128);
    model(64'(n), dbl, 64, e64, eo64, m64);
    bus_write(A_OPERAND, 64'(n));
    bus_write(A_STATUS, {63'b0, dbl});
    s128 = d128_starts; s64 = d64_starts;
    start_and_wait(cyc, to);
    last_cyc = cyc;
    checks++;
    if (to || cyc != m128 * (mul_lat + 2) + 2) begin
      fails++; $display("FAIL latency n=%0d mode=%0d: got %0d cycles (timeout=%0d) expected %0d",
                        n, dbl, cyc, to, m128 * (mul_lat + 2) + 2);
    end
    bus_read(A_OPDONE, r1, r2);
    checks++;
    if (r1 !== 64'd1 || r2 !== 64'd1) begin
      fails++; $display("FAIL opdone n=%0d: got %0h/%0h expected 1/1", n, r1, r2);
    end
    bus_read(A_RESULT_H, r1, r2);
    last_h128 = r1; last_h64 = r2;
    checks++;
    if (r1 !== e128[127:64] || r2 !== 64'd0) begin
      fails++; $display("FAIL result_h n=%0d mode=%0d: got %0h/%0h expected %0h/0", n, dbl, r1, r2, e128[127:64]);
    end
    bus_read(A_RESULT_L, r1, r2);
    last_l128 = r1; last_l64 = r2;
    checks++;
    if (r1 !== e128[63:0] || r2 !== e64[63:0]) begin
      fails++; $display("FAIL result_l n=%0d mode=%0d: got %0h/%0h expected %0h/%0h",
                        n, dbl, r1, r2, e128[63:0], e64[63:0]);
    end
    bus_read(A_STATUS, r1, r2);
    last_ovf128 = r1[8]; last_ovf64 = r2[8];
    checks++;
    if (r1 !== ((64'(eo128) << 8) | 64'(dbl)) || r2 !== ((64'(eo64) << 8) | 64'(dbl))) begin
      fails++; $display("FAIL status n=%0d mode=%0d: got %0h/%0h expected ovf %0d/%0d", n, dbl, r1, r2, eo128, eo64);
    end
    checks++;
    if (d128_starts - s128 != m128 || d64_starts - s64 != m64) begin
      fails++; $display("FAIL start_pulses n=%0d: got %0d/%0d expected %0d", n, d128_starts - s128, d64_starts - s64, m128);
    end
  endtask

  task automatic test_reset;
    logic [63:0] r1, r2;
    checks++;
    if ({d128_mul_start, d128_mul_clear, d128_intr, d64_mul_start, d64_mul_clear, d64_intr} !== 6'b010_010) begin
      fails++; $display("FAIL reset_ctrl: got start/clear/intr %b%b%b %b%b%b expected 010 010", d128_mul_start,
                        d128_mul_clear, d128_intr, d64_mul_start, d64_mul_clear, d64_intr);
    end
    checks++;
    if (d128_mul_a !== 128'd1 || d128_mul_b !== 64'd0 || d64_mul_a !== 64'd1 || d64_mul_b !== 64'd0) begin
      fails++; $display("FAIL reset_operands: got a=%0h b=%0h expected a=1 b=0", d128_mul_a, d128_mul_b);
    end
    checks++;
    if (d128_s_dout !== 64'd0 || d64_s_dout !== 64'd0) begin
      fails++; $display("FAIL reset_dout: got %0h/%0h expected 0", d128_s_dout, d64_s_dout);
    end
    bus_read(A_RESULT_L, r1, r2);
    checks++;
    if (r1 !== 64'd1 || r2 !== 64'd1) begin
      fails++; $display("FAIL reset_result_l: got %0h/%0h expected 1", r1, r2);
    end
    bus_read(A_OPDONE, r1, r2);
    checks++;
    if (r1 !== 64'd0 || r2 !== 64'd0) begin
      fails++; $display("FAIL reset_opdone: got %0h/%0h expected 0", r1, r2);
    end
    bus_read(A_OPERAND, r1, r2);
    checks++;
    if (r1 !== 64'd0 || r2 !== 64'd0) begin
      fails++; $display("FAIL reset_operand: got %0h/%0h expected 0", r1, r2);
    end
    bus_read(A_STATUS, r1, r2);
    checks++;
    if (r1 !== 64'd0 || r2 !== 64'd0) begin
      fails++; $display("FAIL reset_status: got %0h/%0h expected 0", r1, r2);
    end
  endtask

  task automatic test_basic;
    mul_lat = 3;
    run_op(5, 1'b0);
    checks++;
    if (last_l128 !== 64'd120 || last_cyc != 22) begin
      fails++; $display("FAIL fact5: got %0d after %0d cycles expected 120 after 22", last_l128, last_cyc);
    end
  endtask

  task automatic test_zero_one;
    run_op(0, 1'b0);
    run_op(1, 1'b0);
    checks++;
    if (last_l128 !== 64'd1 || last_cyc != 2) begin
      fails++; $display("FAIL fact1: got %0d after %0d cycles expected 1 after 2", last_l128, last_cyc);
    end
    run_op(0, 1'b1);
  endtask

  task automatic test_double;
    mul_lat = 2;
    run_op(7, 1'b1);
    checks++;
    if (last_l128 !== 64'd105) begin fails++; $display("FAIL dfact7: got %0d expected 105", last_l128); end
    run_op(8, 1'b1);
    checks++;
    if (last_l128 !== 64'd384) begin fails++; $display("FAIL dfact8: got %0d expected 384", last_l128); end
  endtask

  task automatic test_overflow;
    mul_lat = 1;
    run_op(21, 1'b0);
    checks++;
    if (last_l64 !== 64'hC5077D36B8C40000 || last_ovf64 !== 1'b1) begin
      fails++; $display("FAIL ovf64_21: got %0h ovf=%0d expected c5077d36b8c40000 ovf=1", last_l64, last_ovf64);
    end
    checks++;
    if (last_h128 !== 64'd2 || last_l128 !== 64'hC5077D36B8C40000 || last_ovf128 !== 1'b0) begin
      fails++; $display("FAIL fact21_128: got %0h_%0h ovf=%0d expected 2_c5077d36b8c40000 ovf=0",
                        last_h128, last_l128, last_ovf128);
    end
    run_op(35, 1'b0);
    checks++;
    if (last_ovf128 !== 1'b1) begin fails++; $display("FAIL ovf128_35: got ovf=%0d expected 1", last_ovf128); end
  endtask

  task automatic test_abort;
    logic [63:0] r1, r2;
    int n;
    mul_lat = 10;
    bus_write(A_OPERAND, 64'd20);
    bus_write(A_STATUS, 64'd0);
    bus_write(A_OPSTART, 64'd1);
    n = 0;
    while (c128 != 1 && n < 300) begin @(negedge clk); #1; n++; end
    checks++;
    if (c128 != 1) begin fails++; $display("FAIL abort_wait: got no multiply in flight expected one"); end
    // OPCLEAR lands one edge before the FSM sees mul_done, so both hit together.
    s_sel = 1'b1; s_wr = 1'b1; s_addr = A_OPCLEAR; s_din = 64'd1;
    @(negedge clk);
    s_sel = 1'b0; s_wr = 1'b0;
    @(negedge clk);
    bus_read(A_RESULT_L, r1, r2);
    checks++;
    if (r1 !== 64'd1 || r2 !== 64'd1) begin fails++; $display("FAIL abort_result: got %0h/%0h expected 1", r1, r2); end
    bus_read(A_OPDONE, r1, r2);
    checks++;
    if (r1 !== 64'd0 || r2 !== 64'd0 || d128_mul_clear !== 1'b1 || d64_mul_clear !== 1'b1) begin
      fails++; $display("FAIL abort_state: got opdone %0h/%0h clear %b%b expected 0/0 clear 11",
                        r1, r2, d128_mul_clear, d64_mul_clear);
    end
    bus_write(A_OPCLEAR, 64'd0);
    mul_lat = 2;
    run_op(3, 1'b0);
    checks++;
    if (last_l128 !== 64'd6) begin fails++; $display("FAIL after_abort: got %0d expected 6", last_l128); end
  endtask

  task automatic test_intr_busy;
    logic [63:0] r1, r2;
    int cyc, bad, s128;
    mul_lat = 2;
    bus_write(A_OPERAND, 64'd4);
    bus_write(A_STATUS, 64'd0);
    s128 = d128_starts;
    bus_write(A_OPSTART, 64'd1);
    bus_write(A_OPERAND, 64'd9);
    bus_write(A_STATUS, 64'd1);
    bus_write(A_OPSTART, 64'd1);
    bus_write(A_INTREN, 64'd1);
    bus_read(A_OPDONE, r1, r2);
    checks++;
    if (r1 !== 64'd2 || r2 !== 64'd2) begin fails++; $display("FAIL busy_flag: got %0h/%0h expected 2", r1, r2); end
    bad = 0; cyc = 0;
    while (cyc < 500) begin
      @(negedge clk); cyc++;
      bus_read(A_OPDONE, r1, r2);
      if (d128_intr !== r1[0] || d64_intr !== r2[0]) bad++;
      if (r1[0]) break;
    end
    checks++;
    if (bad != 0 || d128_intr !== 1'b1 || d64_intr !== 1'b1) begin
      fails++; $display("FAIL intr_track: got %0d mismatched cycles, intr %b%b expected 0, 11", bad, d128_intr, d64_intr);
    end
    bus_read(A_RESULT_L, r1, r2);
    checks++;
    if (r1 !== 64'd24 || r2 !== 64'd24 || d128_starts - s128 != 3) begin
      fails++; $display("FAIL busy_result: got %0d/%0d with %0d multiplies expected 24 with 3", r1, r2, d128_starts - s128);
    end
    bus_read(A_OPERAND, r1, r2);
    checks++;
    if (r1 !== 64'd4 || r2 !== 64'd4) begin fails++; $display("FAIL busy_operand: got %0h/%0h expected 4", r1, r2); end
    bus_read(A_STATUS, r1, r2);
    checks++;
    if (r1 !== 64'd0 || r2 !== 64'd0) begin fails++; $display("FAIL busy_mode: got %0h/%0h expected 0", r1, r2); end
    bus_write(A_OPCLEAR, 64'd1);
    checks++;
    if (d128_intr !== 1'b1) begin fails++; $display("FAIL intr_hold: got %b expected 1", d128_intr); end
    @(negedge clk);
    checks++;
    if (d128_intr !== 1'b0 || d64_intr !== 1'b0) begin
      fails++; $display("FAIL intr_clear: got %b%b expected 00", d128_intr, d64_intr);
    end
    bus_write(A_OPCLEAR, 64'd0);
    bus_write(A_INTREN, 64'd0);
  endtask

  task automatic test_decode;
    logic [63:0] r1, r2;
    bus_write(A_OPERAND, 64'h5A);
    bus_read(16'h0040, r1, r2);
    checks++;
    if (r1 !== 64'd0 || r2 !== 64'd0) begin fails++; $display("FAIL unmapped: got %0h/%0h expected 0", r1, r2); end
    s_addr = A_OPERAND; s_wr = 1'b0; s_sel = 1'b0;
    #1;
    checks++;
    if (d128_s_dout !== 64'd0) begin fails++; $display("FAIL unselected: got %0h expected 0", d128_s_dout); end
    bus_read(A_OPERAND, r1, r2);
    checks++;
    if (r1 !== 64'h5A) begin fails++; $display("FAIL operand_rd: got %0h expected 5a", r1); end
  endtask

  task automatic test_reset_midop;
    logic [63:0] r1, r2;
    mul_lat = 3;
    bus_write(A_INTREN, 64'd1);
    bus_write(A_OPERAND, 64'd30);
    bus_write(A_STATUS, 64'd1);
    bus_write(A_OPSTART, 64'd1);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    bus_read(A_RESULT_L, r1, r2);
    checks++;
    if (r1 !== 64'd1 || r2 !== 64'd1 || d128_mul_clear !== 1'b1 || d128_mul_b !== 64'd0) begin
      fails++; $display("FAIL midop_reset: got result %0h/%0h clear %b b=%0h expected 1/1 1 0", r1, r2, d128_mul_clear, d128_mul_b);
    end
    bus_read(A_INTREN, r1, r2);
    checks++;
    if (r1 !== 64'd0 || r2 !== 64'd0) begin fails++; $display("FAIL midop_intren: got %0h/%0h expected 0", r1, r2); end
    bus_read(A_OPERAND, r1, r2);
    checks++;
    if (r1 !== 64'd0) begin fails++; $display("FAIL midop_operand: got %0h expected 0", r1); end
    run_op(6, 1'b0);
  endtask

  task automatic test_random;
    for (int i = 0; i < 6; i++) begin
      mul_lat = $urandom_range(1, 4);
      run_op($urandom_range(0, 40), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    test_reset;
    test_basic;
    test_zero_one;
    test_double;
    test_overflow;
    test_abort;
    test_intr_busy;
    test_decode;
    test_reset_midop;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
